// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and constants for the instruction prefetch queue
package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
  localparam logic [63:0] INSTR_BYTES = 64'd4;
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: DEPTH-entry circular buffer of fetch entries with push/pop/clear and occupancy count
module fq_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign head = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (!rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  // The upstream credit rule must make overflow impossible
  assert property (@(posedge clk) disable iff (!rst || clear) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction prefetch buffer between imem and IF/ID.
// Optional same-cycle imem->decode bypass when FQ_BYPASS_EN is defined.
module fetch_queue import fetch_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  output logic                         imem_req,
  output logic [63:0]                  imem_addr,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [31:0]                  id_instr,
  output logic [63:0]                  id_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  logic [63:0] fetch_pc, resp_pc, redir_pc;
  logic [OW-1:0] outstanding, drop;
  logic [CW-1:0] count;
  fetch_entry_t head;
  logic push, pop, bypass, accept;
  assign redir_pc  = redirect_pc & ~64'h3;
  assign imem_addr = fetch_pc;
  always_comb begin
    imem_req = rst && !redirect_valid && (int'(count) + int'(outstanding) < DEPTH)
               && (int'(outstanding) < MAX_OUT);
    accept   = rst && !redirect_valid && imem_rvalid && drop == '0;
`ifdef FQ_BYPASS_EN
    bypass   = accept && count == '0;
`else
    bypass   = 1'b0;
`endif
    id_valid = rst && (count != '0 || bypass);
    id_instr = bypass ? imem_rdata : head.instr;
    id_pc    = bypass ? resp_pc : head.pc;
    push     = accept && !(bypass && id_ready);
    pop      = rst && !redirect_valid && count != '0 && id_ready;
    fq_count = rst ? count : '0;
  end
  // A redirect kills everything in flight: responses still owed are counted into drop
  always_ff @(posedge clk)
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_pc;
      resp_pc     <= redir_pc;
      outstanding <= outstanding - OW'(imem_rvalid);
      drop        <= outstanding - OW'(imem_rvalid);
    end else begin
      fetch_pc    <= imem_req ? fetch_pc + INSTR_BYTES : fetch_pc;
      resp_pc     <= accept ? resp_pc + INSTR_BYTES : resp_pc;
      outstanding <= outstanding + OW'(imem_req) - OW'(imem_rvalid);
      drop        <= drop - OW'(imem_rvalid && drop != '0);
    end
  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .wdata ('{pc: resp_pc, instr: imem_rdata}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with an in-order variable-latency imem model
module tb_fetch_queue;
  import fetch_pkg::*;
  logic        clk = 0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [2:0]  fq_count;
  int tests = 0;
  int fails = 0;
  int lat = 1;
  fetch_entry_t exp_q[$];
  logic [63:0] pa[$];
  int pd[$];
  int t = 0;

  fetch_queue dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] minstr(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // imem: requests seen at negedge become responses lat cycles later, in order
  initial begin
    imem_rvalid = 0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pa.delete();
        pd.delete();
      end else begin
        if (imem_rvalid) begin
          void'(pa.pop_front());
          void'(pd.pop_front());
        end
        if (imem_req) begin
          pa.push_back(imem_addr);
          pd.push_back(t + lat);
        end
      end
      @(posedge clk);
      #1;
      t++;
      imem_rvalid = pa.size() > 0 && pd[0] <= t;
      imem_rdata = imem_rvalid ? minstr(pa[0]) : '0;
    end
  end

  // monitor: every decode handshake must match the next expected entry
  initial forever begin
    fetch_entry_t e;
    @(negedge clk);
    if (rst && id_valid && id_ready && !redirect_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deliver_extra: got pc=%h instr=%h, expected no delivery", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          fails++;
          $display("FAIL deliver: got pc=%h instr=%h, expected pc=%h instr=%h", id_pc, id_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic expect_run(logic [63:0] base, int n);
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc = base + 64'(4 * i);
      e.instr = minstr(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(string n);
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL %s: %0d entries undelivered, expected 0", n, exp_q.size());
      exp_q.delete();
    end
    #1;
    id_ready = 0;
  endtask

  task automatic do_reset(int l);
    rst = 0;
    id_ready = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    lat = l;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_count", 64'(fq_count), 64'd0);
    tick();
    rst = 1;
  endtask

  initial begin
    // 1: sequential fetch, latency 1
    do_reset(1);
    id_ready = 1;
    expect_run(64'h0, 8);
    @(negedge clk);
    chk("seq_addr0", imem_addr, 64'h0);
    chk("seq_req0", 64'(imem_req), 64'd1);
    tick();
    @(negedge clk);
    chk("seq_addr1", imem_addr, 64'h4);
`ifdef FQ_BYPASS_EN
    chk("bypass_valid", 64'(id_valid), 64'd1);
`else
    chk("nobypass_valid", 64'(id_valid), 64'd0);
`endif
    tick();
    @(negedge clk);
    chk("seq_addr2", imem_addr, 64'h8);
    drain("seq_drain");
    // 2: decode stall saturates the queue, then releases in order
    do_reset(1);
    repeat (10) tick();
    @(negedge clk);
    chk("stall_count", 64'(fq_count), 64'd4);
    chk("stall_req", 64'(imem_req), 64'd0);
    chk("stall_valid", 64'(id_valid), 64'd1);
    chk("stall_head", id_pc, 64'h0);
    tick();
    expect_run(64'h0, 8);
    id_ready = 1;
    drain("stall_drain");
    // 3: redirect with two requests in flight
    do_reset(2);
    repeat (4) tick();
    @(negedge clk);
    chk("pre_redir_count", 64'(fq_count), 64'd2);
    tick();
    redirect_valid = 1;
    redirect_pc = 64'h40;
    @(negedge clk);
    chk("redir_req", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 0;
    expect_run(64'h40, 8);
    id_ready = 1;
    @(negedge clk);
    chk("post_redir_valid", 64'(id_valid), 64'd0);
    chk("post_redir_count", 64'(fq_count), 64'd0);
    drain("redir_drain");
    // 4: unaligned redirect, then back-to-back redirects
    do_reset(1);
    repeat (2) tick();
    redirect_valid = 1;
    redirect_pc = 64'h103;
    tick();
    redirect_valid = 0;
    @(negedge clk);
    chk("align_req", 64'(imem_req), 64'd1);
    chk("align_addr", imem_addr, 64'h100);
    expect_run(64'h100, 4);
    id_ready = 1;
    drain("align_drain");
    tick();
    redirect_valid = 1;
    redirect_pc = 64'h80;
    tick();
    redirect_pc = 64'hC0;
    @(negedge clk);
    chk("b2b_req", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 0;
    @(negedge clk);
    chk("b2b_valid", 64'(id_valid), 64'd0);
    chk("b2b_addr", imem_addr, 64'hC0);
    expect_run(64'hC0, 4);
    id_ready = 1;
    drain("b2b_drain");
    // 5: reset mid-operation with requests outstanding and entries queued
    do_reset(2);
    repeat (4) tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_req", 64'(imem_req), 64'd0);
    chk("midrst_valid", 64'(id_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("midrst_count", 64'(fq_count), 64'd0);
    tick();
    rst = 1;
    id_ready = 1;
    expect_run(64'h0, 4);
    @(negedge clk);
    chk("midrst_addr", imem_addr, 64'h0);
    chk("midrst_req1", 64'(imem_req), 64'd1);
    drain("midrst_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
